// File: rtl/instmem_load_arbiter.sv
// ---------------------------------------------------------------------------
// instmem_load_arbiter
//
// Owns the single instruction-memory port and shares it between CPU fetch
// and a host program loader. While idle the CPU fetches with zero latency
// straight through the port. A load request stalls the CPU and streams a
// block of words into memory through a valid/ready handshake, one word per
// cycle at full rate. The loader then spends one DONE cycle before the port
// returns to fetch.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   cpu_addr          fetch address (PC)
//   cpu_instr         fetched instruction (zero while the CPU is stalled)
//   cpu_stall         CPU must hold its PC and ignore cpu_instr
//   ld_start          single-cycle load request (only honoured in IDLE)
//   ld_base, ld_len   first address and word count, sampled with ld_start
//   ld_abort          terminate the load in progress
//   ld_valid/ld_data  loader word stream
//   ld_ready          arbiter accepts a word this cycle
//   ld_busy           load in progress
//   ld_done           one-cycle completion pulse
//   ld_count          words accepted in the current or last load
//   mem_*             instruction memory port (combinational read)
//
// Optional feature (macro LOAD_CHECKSUM_EN):
//   Adds output ld_checksum, the running sum mod 2^DATA_W of every word
//   accepted in the current load.
// ---------------------------------------------------------------------------
module instmem_load_arbiter #(
    parameter  int ADDR_W    = 16,
    parameter  int DATA_W    = 32,
    parameter  int MAX_WORDS = 256,
    localparam int LEN_W     = $clog2(MAX_WORDS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_stall,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [LEN_W-1:0]  ld_len,
    input  logic              ld_abort,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [LEN_W-1:0]  ld_count,
`ifdef LOAD_CHECKSUM_EN
    output logic [DATA_W-1:0] ld_checksum,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  base;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   len_clamped;
    logic [ADDR_W-1:0]  write_addr;
    logic               beat;
    logic               accept_start;
`ifdef LOAD_CHECKSUM_EN
    logic [DATA_W-1:0]  checksum;
`endif

    // A zero-length request is dropped entirely; oversize requests are
    // clamped so a load never exceeds MAX_WORDS beats.
    assign accept_start = (state == IDLE) && ld_start && (ld_len != '0);
    assign len_clamped  = (ld_len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : ld_len;

    // The write address wraps naturally at the top of the address space
    // because the sum is truncated to ADDR_W bits.
    assign write_addr = base + ADDR_W'(count);
    assign ld_count   = count;

    // State register plus the load bookkeeping (base, length, word count).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            base  <= '0;
            len   <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (accept_start) begin
                base  <= ld_base;
                len   <= len_clamped;
                count <= '0;
            end else if (beat) begin
                count <= count + LEN_W'(1);
            end
        end
    end

    // Next-state and port steering. In IDLE the CPU owns the memory port;
    // in LOAD and DONE the CPU is stalled and sees zero on cpu_instr.
    always_comb begin
        state_next = state;
        beat       = 1'b0;
        cpu_instr  = '0;
        cpu_stall  = 1'b0;
        ld_ready   = 1'b0;
        ld_busy    = 1'b0;
        ld_done    = 1'b0;
        mem_addr   = cpu_addr;
        mem_write  = 1'b0;
        mem_datain = ld_data;
        case (state)
            IDLE: begin
                cpu_instr = mem_dataout;
                if (accept_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cpu_stall = 1'b1;
                ld_busy   = 1'b1;
                ld_ready  = ~ld_abort;
                beat      = ld_valid & ~ld_abort;
                mem_write = beat;
                mem_addr  = write_addr;
                if (ld_abort) begin
                    state_next = IDLE;
                end else if (beat && (count == len - LEN_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_stall  = 1'b1;
                ld_done    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef LOAD_CHECKSUM_EN
    // Running sum of accepted words; holds after the load until the next
    // accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (accept_start) begin
            checksum <= '0;
        end else if (beat) begin
            checksum <= checksum + ld_data;
        end
    end

    assign ld_checksum = checksum;
`endif

endmodule

// File: tb/tb_instmem_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_instmem_load_arbiter
//
// Self-checking bench for instmem_load_arbiter. A behavioural instruction
// memory sits on the mem_* port; a separate reference image (associative
// array) records what the loads should have put in memory, and every fetch
// is compared against it. Optional checksum checks follow LOAD_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_instmem_load_arbiter;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int MAX_WORDS = 256;
    localparam int LEN_W     = 9;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_instr;
    logic              cpu_stall;
    logic              ld_start = 1'b0;
    logic [ADDR_W-1:0] ld_base = '0;
    logic [LEN_W-1:0]  ld_len = '0;
    logic              ld_abort = 1'b0;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;
    logic [LEN_W-1:0]  ld_count;
`ifdef LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] ld_checksum;
`endif
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_datain;
    logic [DATA_W-1:0] mem_dataout;

    int checks = 0;
    int errors = 0;
    int lastCount = 0;

    bit   [DATA_W-1:0] memArr     [0:65535];
    bit                memWritten [0:65535];
    logic [DATA_W-1:0] refMem     [int];

    instmem_load_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_instr  (cpu_instr),
        .cpu_stall  (cpu_stall),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_len     (ld_len),
        .ld_abort   (ld_abort),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .ld_count   (ld_count),
`ifdef LOAD_CHECKSUM_EN
        .ld_checksum(ld_checksum),
`endif
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_datain (mem_datain),
        .mem_dataout(mem_dataout)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Unwritten locations read back a fixed pattern derived from the address.
    function automatic logic [DATA_W-1:0] initWord(input logic [ADDR_W-1:0] a);
        return {a, ~a};
    endfunction

    // Expected memory content: loaded words override the power-up pattern.
    function automatic logic [DATA_W-1:0] refRead(input logic [ADDR_W-1:0] a);
        if (refMem.exists(int'(a))) return refMem[int'(a)];
        return initWord(a);
    endfunction

    // Behavioural instruction memory with a combinational read port.
    always @(posedge clk) begin
        if (mem_write === 1'b1) begin
            memArr[mem_addr]     <= mem_datain;
            memWritten[mem_addr] <= 1'b1;
        end
    end

    assign mem_dataout = memWritten[mem_addr] ? memArr[mem_addr] : initWord(mem_addr);

    // Drives one complete load and checks it cycle by cycle.
    // validMode: 0 = always valid, 1 = valid every third cycle, 2 = random.
    task automatic do_load(input logic [ADDR_W-1:0] base, input int lenReq,
                           input int validMode, input int abortAfter,
                           input bit seqData, input bit noiseStart,
                           output int beatsOut, output int cyclesOut,
                           output logic [DATA_W-1:0] sumOut);
        int                effLen;
        int                beats;
        int                cycles;
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] expAddr;
        bit                vld;
        bit                abt;
        bit                finished;
        bit                aborted;
        effLen   = (lenReq > MAX_WORDS) ? MAX_WORDS : lenReq;
        beats    = 0;
        cycles   = 0;
        sum      = '0;
        finished = 1'b0;
        aborted  = 1'b0;

        @(posedge clk); #1;
        ld_start = 1'b1;
        ld_base  = base;
        ld_len   = LEN_W'(lenReq);
        ld_valid = 1'b0;
        ld_abort = 1'b0;
        cpu_addr = ADDR_W'($urandom);
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_write !== 1'b0 || mem_addr !== cpu_addr) begin
            errors++;
            $display("[TB] FAIL start_cycle: stall=%b write=%b addr=%h, expected stall=0 write=0 addr=%h",
                     cpu_stall, mem_write, mem_addr, cpu_addr);
        end
        @(posedge clk); #1;
        ld_start = 1'b0;

        while (!finished) begin
            if (cycles >= 4000) begin
                checks++;
                errors++;
                $display("[TB] FAIL load_timeout: %0d beats after %0d cycles, expected %0d beats",
                         beats, cycles, effLen);
                aborted = 1'b1;
                break;
            end
            case (validMode)
                0:       vld = 1'b1;
                1:       vld = (cycles % 3 == 0);
                default: vld = ($urandom_range(3) != 0);
            endcase
            abt      = (abortAfter >= 0) && (beats == abortAfter);
            data     = seqData ? (32'hA0 + DATA_W'(beats)) : DATA_W'($urandom);
            ld_valid = vld;
            ld_abort = abt;
            ld_data  = data;
            cpu_addr = ADDR_W'($urandom);
            ld_start = noiseStart ? ($urandom_range(3) == 0) : 1'b0;
            ld_base  = ADDR_W'($urandom);
            ld_len   = LEN_W'($urandom);
            @(negedge clk);
            checks++;
            if ({ld_busy, cpu_stall, ld_ready, ld_done} !== {1'b1, 1'b1, !abt, 1'b0}) begin
                errors++;
                $display("[TB] FAIL load_status: busy/stall/ready/done=%b%b%b%b, expected 11%b0",
                         ld_busy, cpu_stall, ld_ready, ld_done, !abt);
            end
            checks++;
            if (cpu_instr !== '0) begin
                errors++;
                $display("[TB] FAIL stalled_instr: got %h, expected 0", cpu_instr);
            end
            checks++;
            if (mem_write !== (vld && !abt)) begin
                errors++;
                $display("[TB] FAIL load_write: got %b, expected %b", mem_write, vld && !abt);
            end
            if (vld && !abt) begin
                expAddr = base + ADDR_W'(beats);
                checks++;
                if (mem_addr !== expAddr || mem_datain !== data) begin
                    errors++;
                    $display("[TB] FAIL load_beat: addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_datain, expAddr, data);
                end
                refMem[int'(expAddr)] = data;
                sum   = sum + data;
                beats = beats + 1;
                if (beats == effLen) finished = 1'b1;
            end
            if (abt) begin
                finished = 1'b1;
                aborted  = 1'b1;
            end
            cycles++;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        ld_abort = 1'b0;
        ld_start = 1'b0;

        if (!aborted) begin
            @(negedge clk);
            checks++;
            if ({ld_done, cpu_stall, ld_ready, mem_write, ld_busy} !== 5'b11000) begin
                errors++;
                $display("[TB] FAIL done_cycle: done/stall/ready/write/busy=%b%b%b%b%b, expected 11000",
                         ld_done, cpu_stall, ld_ready, mem_write, ld_busy);
            end
            checks++;
            if (ld_count !== LEN_W'(effLen)) begin
                errors++;
                $display("[TB] FAIL done_count: got %0d, expected %0d", ld_count, effLen);
            end
`ifdef LOAD_CHECKSUM_EN
            checks++;
            if (ld_checksum !== sum) begin
                errors++;
                $display("[TB] FAIL done_checksum: got %h, expected %h", ld_checksum, sum);
            end
`endif
            @(posedge clk); #1;
        end

        cpu_addr = (beats > 0) ? base + ADDR_W'($urandom_range(beats - 1)) : ADDR_W'($urandom);
        @(negedge clk);
        checks++;
        if ({ld_done, cpu_stall, ld_busy, ld_ready, mem_write} !== 5'b00000 || mem_addr !== cpu_addr) begin
            errors++;
            $display("[TB] FAIL back_to_idle: done/stall/busy/ready/write=%b%b%b%b%b addr=%h, expected 00000 addr=%h",
                     ld_done, cpu_stall, ld_busy, ld_ready, mem_write, mem_addr, cpu_addr);
        end
        checks++;
        if (ld_count !== LEN_W'(beats)) begin
            errors++;
            $display("[TB] FAIL idle_count: got %0d, expected %0d", ld_count, beats);
        end
        checks++;
        if (cpu_instr !== refRead(cpu_addr)) begin
            errors++;
            $display("[TB] FAIL fetch_after_load: addr %h got %h, expected %h",
                     cpu_addr, cpu_instr, refRead(cpu_addr));
        end
`ifdef LOAD_CHECKSUM_EN
        if (!aborted) begin
            checks++;
            if (ld_checksum !== sum) begin
                errors++;
                $display("[TB] FAIL held_checksum: got %h, expected %h", ld_checksum, sum);
            end
        end
`endif
        lastCount = beats;
        beatsOut  = beats;
        cyclesOut = cycles;
        sumOut    = sum;
    endtask

    // Outputs while held in reset, then the first fetch after release.
    task automatic test_reset();
        #12;
        checks++;
        if ({cpu_stall, mem_write, ld_ready, ld_busy, ld_done} !== 5'b00000 || ld_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: stall/write/ready/busy/done=%b%b%b%b%b count=%0d, expected 00000 count=0",
                     cpu_stall, mem_write, ld_ready, ld_busy, ld_done, ld_count);
        end
        @(negedge clk);
        reset    = 1'b1;
        cpu_addr = 16'd3;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'd3 || cpu_stall !== 1'b0 || mem_write !== 1'b0 || ld_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_fetch: addr=%h stall=%b write=%b ready=%b, expected addr=0003 stall=0 write=0 ready=0",
                     mem_addr, cpu_stall, mem_write, ld_ready);
        end
        checks++;
        if (cpu_instr !== refRead(16'd3)) begin
            errors++;
            $display("[TB] FAIL reset_instr: got %h, expected %h", cpu_instr, refRead(16'd3));
        end
    endtask

    // Four words A0..A3 into 0x10..0x13 at full rate.
    task automatic test_basic_load();
        int                beats;
        int                cycles;
        logic [DATA_W-1:0] sum;
        do_load(16'h0010, 4, 0, -1, 1'b1, 1'b0, beats, cycles, sum);
        checks++;
        if (cycles != 4 || beats != 4 || sum != 32'h286) begin
            errors++;
            $display("[TB] FAIL basic_load: cycles=%0d beats=%0d sum=%h, expected 4 4 00000286",
                     cycles, beats, sum);
        end
    endtask

    // ld_valid pattern 1,0,0,1: two beats spread over four LOAD cycles.
    task automatic test_throttled();
        int                beats;
        int                cycles;
        logic [DATA_W-1:0] sum;
        do_load(16'h0400, 2, 1, -1, 1'b0, 1'b0, beats, cycles, sum);
        checks++;
        if (cycles != 4 || beats != 2) begin
            errors++;
            $display("[TB] FAIL throttled: cycles=%0d beats=%0d, expected 4 2", cycles, beats);
        end
    endtask

    // Abort after three beats of an eight-word load.
    task automatic test_abort();
        int                beats;
        int                cycles;
        logic [DATA_W-1:0] sum;
        do_load(16'h0800, 8, 0, 3, 1'b0, 1'b0, beats, cycles, sum);
        checks++;
        if (beats != 3 || cycles != 4) begin
            errors++;
            $display("[TB] FAIL abort: beats=%0d cycles=%0d, expected 3 4", beats, cycles);
        end
    endtask

    // Load across the top of the address space.
    task automatic test_wrap();
        int                beats;
        int                cycles;
        logic [DATA_W-1:0] sum;
        do_load(16'hFFFF, 2, 0, -1, 1'b0, 1'b0, beats, cycles, sum);
        cpu_addr = 16'h0000;
        @(negedge clk);
        checks++;
        if (cpu_instr !== refRead(16'h0000)) begin
            errors++;
            $display("[TB] FAIL wrap_fetch: got %h, expected %h", cpu_instr, refRead(16'h0000));
        end
    endtask

    // A zero-length request must leave the arbiter idle with no done pulse.
    task automatic test_zero_len();
        @(posedge clk); #1;
        ld_start = 1'b1;
        ld_len   = '0;
        ld_base  = 16'h1234;
        @(posedge clk); #1;
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_stall, ld_busy, ld_done, mem_write} !== 4'b0000 || ld_count !== LEN_W'(lastCount)) begin
                errors++;
                $display("[TB] FAIL zero_len: stall/busy/done/write=%b%b%b%b count=%0d, expected 0000 count=%0d",
                         cpu_stall, ld_busy, ld_done, mem_write, ld_count, lastCount);
            end
            @(posedge clk); #1;
        end
    endtask

    // Oversize request is clamped to MAX_WORDS beats.
    task automatic test_clamp();
        int                beats;
        int                cycles;
        logic [DATA_W-1:0] sum;
        do_load(ADDR_W'($urandom), 300, 2, -1, 1'b0, 1'b0, beats, cycles, sum);
        checks++;
        if (beats != MAX_WORDS) begin
            errors++;
            $display("[TB] FAIL clamp: beats=%0d, expected %0d", beats, MAX_WORDS);
        end
    endtask

    // Random loads with throttled data and stray ld_start pulses mid-load.
    task automatic test_random_loads();
        int                beats;
        int                cycles;
        logic [DATA_W-1:0] sum;
        for (int n = 0; n < 6; n++) begin
            do_load(ADDR_W'($urandom), $urandom_range(40, 1), 2, -1, 1'b0, 1'b1, beats, cycles, sum);
        end
    endtask

    // Reset asserted between clock edges in the middle of a load.
    task automatic test_async_reset();
        logic [DATA_W-1:0] data;
        @(posedge clk); #1;
        ld_start = 1'b1;
        ld_base  = 16'h2000;
        ld_len   = LEN_W'(10);
        @(posedge clk); #1;
        ld_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data     = DATA_W'($urandom);
            ld_valid = 1'b1;
            ld_data  = data;
            @(negedge clk);
            refMem[int'(16'h2000 + k)] = data;
            @(posedge clk); #1;
        end
        #2;
        checks++;
        if (ld_busy !== 1'b1 || cpu_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_busy: busy=%b stall=%b, expected 1 1", ld_busy, cpu_stall);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ld_busy !== 1'b0 || cpu_stall !== 1'b0 || mem_write !== 1'b0 || ld_count !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: busy=%b stall=%b write=%b count=%0d, expected 0 0 0 0",
                     ld_busy, cpu_stall, mem_write, ld_count);
        end
        ld_valid = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b1;
        lastCount = 0;
        cpu_addr  = 16'h2001;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || ld_busy !== 1'b0 || mem_addr !== 16'h2001 || cpu_instr !== refRead(16'h2001)) begin
            errors++;
            $display("[TB] FAIL after_reset: stall=%b busy=%b addr=%h instr=%h, expected 0 0 2001 %h",
                     cpu_stall, ld_busy, mem_addr, cpu_instr, refRead(16'h2001));
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_throttled();
        test_abort();
        test_wrap();
        test_zero_len();
        test_clamp();
        test_random_loads();
        test_zero_len();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instmem_load_arbiter.md
Name: instmem_load_arbiter

Overview:
- Sole owner of the instruction-memory port (addr/write/datain/dataout).
- Arbitrates between CPU instruction fetch and a host program loader.
- On a load request, stalls the CPU and streams N words into memory from a base address via a valid/ready handshake, then returns the port to fetch.
- Sits between the fetch stage, the host/boot interface and the instruction memory.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 32, instruction word width
MAX_WORDS, 256, maximum words per load; ld_len values above this are clamped

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_addr  in  ADDR_W  fetch address (PC)
cpu_instr  out  DATA_W  fetched instruction
cpu_stall  out  1  CPU must hold PC and not consume cpu_instr
ld_start  in  1  single-cycle load request
ld_base  in  ADDR_W  first write address, sampled with ld_start
ld_len  in  $clog2(MAX_WORDS)+1  word count, sampled with ld_start
ld_abort  in  1  terminate the load in progress
ld_valid  in  1  ld_data valid
ld_data  in  DATA_W  word to write
ld_ready  out  1  arbiter accepts a word this cycle
ld_busy  out  1  load in progress (LOAD state)
ld_done  out  1  one-cycle pulse on load completion
ld_count  out  $clog2(MAX_WORDS)+1  words accepted in the current or last load
mem_addr  out  ADDR_W  to memory addr
mem_write  out  1  to memory write
mem_datain  out  DATA_W  to memory datain
mem_dataout  in  DATA_W  from memory dataout (combinational read)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; base, len and count cleared to 0.
  - Outputs: ld_ready=0, ld_busy=0, ld_done=0, cpu_stall=0, mem_write=0, ld_count=0.
  - Reset during LOAD abandons the load; words already written stay in memory.
- FSM states IDLE, LOAD, DONE. All transitions on posedge clk.
- IDLE:
  - mem_addr=cpu_addr, mem_write=0, cpu_instr=mem_dataout (zero-latency fetch), cpu_stall=0.
  - ld_start with ld_len!=0: latch base=ld_base, len=min(ld_len,MAX_WORDS), count=0; go to LOAD.
  - ld_start with ld_len==0: ignored, no ld_done.
- LOAD:
  - cpu_stall=1, cpu_instr=0, ld_busy=1, ld_ready=~ld_abort.
  - Beat = ld_valid & ld_ready. On a beat, combinationally: mem_write=1, mem_addr=(base+count) mod 2^ADDR_W, mem_datain=ld_data. count increments at the clock edge.
  - No beat: mem_write=0, mem_addr=base+count.
  - Beat with count==len-1: go to DONE.
  - ld_abort=1: no beat that cycle; go to IDLE; no ld_done; ld_count holds the words written.
  - ld_start in LOAD or DONE is ignored.
- DONE (exactly one cycle):
  - ld_done=1, cpu_stall=1, ld_ready=0, mem_write=0; then go to IDLE.
  - Earliest fetch after a load is the cycle after DONE.
- ld_count:
  - Registered; cleared on load start.
  - Holds its value in IDLE until the next accepted ld_start.
- Address wrap: base+count truncates to ADDR_W bits (0xFFFF+1 → 0x0000).
- Latency: one write per cycle at full rate. An N-word load occupies N LOAD cycles plus 1 DONE cycle when ld_valid stays high.

Optional Feature:
- Macro LOAD_CHECKSUM_EN.
- Defined:
  - Adds output ld_checksum [DATA_W-1:0]: the sum mod 2^DATA_W of all words accepted in the current load.
  - Cleared on accepted ld_start, updated on each beat, stable and valid while ld_done=1 and afterwards until the next load.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Reset: release reset, cpu_addr=3 → mem_addr=3, cpu_stall=0, mem_write=0, ld_ready=0.
- Basic load: ld_start, ld_base=0x10, ld_len=4, ld_valid held high, data 0xA0..0xA3 → writes to 0x10..0x13 in 4 consecutive cycles, ld_done pulses on cycle 5, ld_count=4, cpu_stall=1 throughout. With LOAD_CHECKSUM_EN, ld_checksum=0x286.
- Throttled source: ld_valid toggles 1,0,0,1,... with ld_len=2 → exactly 2 writes, mem_write low in gap cycles, count advances only on beats.
- Abort: ld_len=8, ld_abort asserted after 3 beats while ld_valid=1 → no write in the abort cycle, IDLE next cycle, no ld_done, ld_count=3, fetch resumes.
- Boundaries:
  - ld_base=0xFFFF, ld_len=2 → writes to 0xFFFF then 0x0000.
  - ld_len=0 → no state change.
  - ld_len=300 → clamped to 256 writes.
- Async reset mid-load: reset=0 asynchronously in LOAD → ld_busy and cpu_stall drop immediately without waiting for clk; after release, state=IDLE.
